// File: rtl/note_sequencer_if.sv
// Chart-player bus: control strobes, chart memory port and per-lane outputs.
interface note_sequencer_if #(
    parameter int unsigned NUM_LANES = 4,
    parameter int unsigned AW        = 6
);
    logic                 frame_tick;
    logic                 start;
    logic                 pause;
    logic                 abort;
    logic [AW-1:0]        chart_addr;
    logic [NUM_LANES:0]   chart_data;
    logic [NUM_LANES-1:0] drop_block;
    logic                 busy;
    logic                 done;
    logic [AW-1:0]        step_idx;
    logic [15:0]          note_count;

    modport master (
        output frame_tick, start, pause, abort, chart_data,
        input  chart_addr, drop_block, busy, done, step_idx, note_count
    );

    modport slave (
        input  frame_tick, start, pause, abort, chart_data,
        output chart_addr, drop_block, busy, done, step_idx, note_count
    );
endinterface

// File: rtl/note_sequencer.sv
// Chart player: steps through lane-hit words from chart memory and drives
// frame-aligned drop_block levels to the lane renderers.
module note_sequencer #(
    parameter int unsigned NUM_LANES    = 4,
    parameter int unsigned CHART_DEPTH  = 64,
    parameter int unsigned STEP_FRAMES  = 8,
    parameter int unsigned BLOCK_FRAMES = 3
) (
    input  logic            clk,
    input  logic            reset,
    note_sequencer_if.slave bus
);
    localparam int unsigned AW  = $clog2(CHART_DEPTH);
    localparam int unsigned FW  = $clog2(STEP_FRAMES);
    localparam int unsigned FLW = FW + 1;
    localparam int unsigned CW  = 16;
    localparam int unsigned SW  = CW + 1;

    localparam logic [FW-1:0]  LAST_FRAME = FW'(STEP_FRAMES - 1);
    localparam logic [FLW-1:0] BLOCK_LIM  = FLW'(BLOCK_FRAMES);
    localparam logic [AW-1:0]  LAST_STEP  = AW'(CHART_DEPTH - 1);
    localparam logic [CW-1:0]  CNT_MAX    = {CW{1'b1}};

    typedef enum logic [1:0] {IDLE, LOAD, PLAY, DONE} state_e;

    state_e               state_q, state_d;
    logic [AW-1:0]        chart_addr_q, chart_addr_d;
    logic [AW-1:0]        step_idx_q, step_idx_d;
    logic [FW-1:0]        frame_cnt_q, frame_cnt_d;
    logic [NUM_LANES-1:0] step_hits_q, step_hits_d;
    logic [NUM_LANES-1:0] drop_q, drop_d;
    logic [CW-1:0]        note_count_q, note_count_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic [SW-1:0]        count_sum;

    function automatic logic [SW-1:0] popcount(input logic [NUM_LANES-1:0] v);
        logic [SW-1:0] n;
        n = '0;
        for (int i = 0; i < int'(NUM_LANES); i++) n = n + SW'(v[i]);
        return n;
    endfunction

    assign count_sum = SW'(note_count_q) + popcount(step_hits_q);

    // Next-state and next-output logic; abort overrides everything else.
    always_comb begin
        state_d      = state_q;
        chart_addr_d = chart_addr_q;
        step_idx_d   = step_idx_q;
        frame_cnt_d  = frame_cnt_q;
        step_hits_d  = step_hits_q;
        drop_d       = drop_q;
        note_count_d = note_count_q;

        if (bus.abort) begin
            state_d = IDLE;
            drop_d  = '0;
        end else begin
            unique case (state_q)
                IDLE, DONE: begin
                    if (bus.frame_tick) drop_d = '0;
                    if (bus.start) begin
                        state_d      = LOAD;
                        chart_addr_d = '0;
                        step_idx_d   = '0;
                        note_count_d = '0;
                        frame_cnt_d  = '0;
                    end
                end
                LOAD: begin
                    step_hits_d = bus.chart_data[NUM_LANES-1:0];
                    if (bus.chart_data[NUM_LANES]) begin
                        state_d = DONE;
                        drop_d  = '0;
                    end else begin
                        state_d = PLAY;
                    end
                end
                PLAY: begin
                    if (bus.frame_tick && bus.pause) begin
                        drop_d = '0;
                    end else if (bus.frame_tick) begin
                        drop_d = ({1'b0, frame_cnt_q} < BLOCK_LIM) ? step_hits_q : '0;
                        if (frame_cnt_q == '0)
                            note_count_d = count_sum[CW] ? CNT_MAX : count_sum[CW-1:0];
                        if (frame_cnt_q == LAST_FRAME) begin
                            frame_cnt_d = '0;
                            // The final chart word never wraps back to address 0.
                            if (step_idx_q == LAST_STEP) begin
                                state_d = DONE;
                            end else begin
                                state_d      = LOAD;
                                chart_addr_d = chart_addr_q + AW'(1);
                                step_idx_d   = step_idx_q + AW'(1);
                            end
                        end else begin
                            frame_cnt_d = frame_cnt_q + FW'(1);
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        busy_d = (state_d == LOAD) || (state_d == PLAY);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            chart_addr_q <= '0;
            step_idx_q   <= '0;
            frame_cnt_q  <= '0;
            step_hits_q  <= '0;
            drop_q       <= '0;
            note_count_q <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            chart_addr_q <= chart_addr_d;
            step_idx_q   <= step_idx_d;
            frame_cnt_q  <= frame_cnt_d;
            step_hits_q  <= step_hits_d;
            drop_q       <= drop_d;
            note_count_q <= note_count_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    assign bus.chart_addr = chart_addr_q;
    assign bus.drop_block = drop_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.step_idx   = step_idx_q;
    assign bus.note_count = note_count_q;
endmodule

// File: tb/tb_note_sequencer.sv
// Bench for note_sequencer: a 4-lane player with a small chart and a
// 16-lane two-frame-step player used to reach note_count saturation.
module tb_note_sequencer;
    localparam int unsigned NL     = 4;
    localparam int unsigned DEPTH  = 4;
    localparam int unsigned AW     = 2;
    localparam int unsigned NL2    = 16;
    localparam int unsigned DEPTH2 = 8192;
    localparam int unsigned AW2    = 13;

    logic        clk = 1'b0;
    logic        reset;
    int          checks = 0;
    int          errors = 0;
    logic [15:0] exp_q[$];
    logic [NL:0] chart [DEPTH];

    note_sequencer_if #(.NUM_LANES(NL),  .AW(AW))  sif  ();
    note_sequencer_if #(.NUM_LANES(NL2), .AW(AW2)) sif2 ();

    note_sequencer #(
        .NUM_LANES(NL), .CHART_DEPTH(DEPTH), .STEP_FRAMES(8), .BLOCK_FRAMES(3)
    ) dut (
        .clk(clk), .reset(reset), .bus(sif)
    );

    note_sequencer #(
        .NUM_LANES(NL2), .CHART_DEPTH(DEPTH2), .STEP_FRAMES(2), .BLOCK_FRAMES(2)
    ) dut6 (
        .clk(clk), .reset(reset), .bus(sif2)
    );

    always #5 clk = ~clk;

    assign sif.chart_data  = chart[sif.chart_addr];
    assign sif2.chart_data = {1'b0, 16'hFFFF};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // One frame tick on the selected player; expected drop_block goes through the scoreboard.
    task automatic tick(input int sel, input logic [15:0] exp, input logic with_abort);
        logic [15:0] e;
        exp_q.push_back(exp);
        if (sel == 0) begin
            sif.frame_tick = 1'b1;
            sif.abort      = with_abort;
        end else begin
            sif2.frame_tick = 1'b1;
        end
        cyc(1);
        sif.frame_tick  = 1'b0;
        sif.abort       = 1'b0;
        sif2.frame_tick = 1'b0;
        e = exp_q.pop_front();
        if (sel == 0) check("drop", 32'(sif.drop_block), 32'(e));
        else          check("drop6", 32'(sif2.drop_block), 32'(e));
        cyc(2);
    endtask

    task automatic start_play(input int sel);
        if (sel == 0) sif.start = 1'b1;
        else          sif2.start = 1'b1;
        cyc(1);
        sif.start  = 1'b0;
        sif2.start = 1'b0;
        if (sel == 0) check("busy_load", 32'(sif.busy), 32'd1);
        else          check("busy_load6", 32'(sif2.busy), 32'd1);
        cyc(2);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [15:0] e;
        int          cnt;
        reset = 1'b1;
        sif.frame_tick = 1'b0; sif.start = 1'b0; sif.pause = 1'b0; sif.abort = 1'b0;
        sif2.frame_tick = 1'b0; sif2.start = 1'b0; sif2.pause = 1'b0; sif2.abort = 1'b0;
        for (int i = 0; i < int'(DEPTH); i++) chart[i] = '0;
        cyc(3);
        check("rst_drop",  32'(sif.drop_block), 32'd0);
        check("rst_busy",  32'(sif.busy), 32'd0);
        check("rst_done",  32'(sif.done), 32'd0);
        check("rst_addr",  32'(sif.chart_addr), 32'd0);
        check("rst_step",  32'(sif.step_idx), 32'd0);
        check("rst_count", 32'(sif.note_count), 32'd0);
        reset = 1'b0;
        cyc(2);

        // Single step then end-of-chart.
        chart[0] = 5'b0_0101;
        chart[1] = 5'b1_0000;
        start_play(0);
        for (int k = 1; k <= 20; k++) begin
            tick(0, (k <= 3) ? 16'h5 : 16'h0, 1'b0);
            if (k == 8) check("t1_addr", 32'(sif.chart_addr), 32'd1);
        end
        check("t1_done",  32'(sif.done), 32'd1);
        check("t1_busy",  32'(sif.busy), 32'd0);
        check("t1_count", 32'(sif.note_count), 32'd2);

        // No end flag: playback stops on the last address.
        for (int i = 0; i < int'(DEPTH); i++) chart[i] = 5'b0_1111;
        start_play(0);
        for (int k = 1; k <= 36; k++) begin
            tick(0, (k <= 32 && ((k - 1) % 8) < 3) ? 16'hF : 16'h0, 1'b0);
            if (k == 31) check("t2_done_early", 32'(sif.done), 32'd0);
            if (k == 32) begin
                check("t2_done", 32'(sif.done), 32'd1);
                check("t2_addr", 32'(sif.chart_addr), 32'd3);
                check("t2_step", 32'(sif.step_idx), 32'd3);
            end
        end
        check("t2_count", 32'(sif.note_count), 32'd16);
        check("t2_addr_hold", 32'(sif.chart_addr), 32'd3);

        // Pause over ticks 2-5 freezes the frame counter at 1.
        chart[0] = 5'b0_0011;
        chart[1] = 5'b1_0000;
        start_play(0);
        for (int k = 1; k <= 14; k++) begin
            sif.pause = (k >= 2 && k <= 5);
            tick(0, (k == 1 || k == 6 || k == 7) ? 16'h3 : 16'h0, 1'b0);
            sif.pause = 1'b0;
            if (k == 11) check("t3_addr_11", 32'(sif.chart_addr), 32'd0);
            if (k == 12) check("t3_addr_12", 32'(sif.chart_addr), 32'd1);
        end
        check("t3_done",  32'(sif.done), 32'd1);
        check("t3_count", 32'(sif.note_count), 32'd2);

        // Abort coincident with a frame tick.
        for (int i = 0; i < int'(DEPTH); i++) chart[i] = 5'b0_1111;
        start_play(0);
        tick(0, 16'hF, 1'b0);
        tick(0, 16'h0, 1'b1);
        check("t4_busy",  32'(sif.busy), 32'd0);
        check("t4_done",  32'(sif.done), 32'd0);
        check("t4_count", 32'(sif.note_count), 32'd4);
        check("t4_step",  32'(sif.step_idx), 32'd0);
        for (int k = 0; k < 3; k++) tick(0, 16'h0, 1'b0);
        check("t4_idle", 32'(sif.busy), 32'd0);

        // Asynchronous reset mid-play, then replay from address 0.
        start_play(0);
        for (int k = 1; k <= 9; k++) tick(0, (k <= 3 || k == 9) ? 16'hF : 16'h0, 1'b0);
        check("t5_addr_pre",  32'(sif.chart_addr), 32'd1);
        check("t5_count_pre", 32'(sif.note_count), 32'd8);
        #2;
        reset = 1'b1;
        #1;
        check("t5_drop",  32'(sif.drop_block), 32'd0);
        check("t5_busy",  32'(sif.busy), 32'd0);
        check("t5_addr",  32'(sif.chart_addr), 32'd0);
        check("t5_step",  32'(sif.step_idx), 32'd0);
        check("t5_count", 32'(sif.note_count), 32'd0);
        cyc(1);
        reset = 1'b0;
        cyc(1);
        start_play(0);
        check("t5_replay_addr", 32'(sif.chart_addr), 32'd0);
        tick(0, 16'hF, 1'b0);
        check("t5_replay_count", 32'(sif.note_count), 32'd4);

        // Two-frame steps, every lane hit every step, run into saturation.
        start_play(1);
        for (int s = 0; s <= 4096; s++) begin
            tick(1, 16'hFFFF, 1'b0);
            if (s < 3 || s >= 4094) begin
                cnt = 16 * (s + 1);
                if (cnt > 65535) cnt = 65535;
                e = 16'(cnt);
                check("t6_count", 32'(sif2.note_count), 32'(e));
            end
            tick(1, 16'hFFFF, 1'b0);
        end
        check("t6_step", 32'(sif2.step_idx), 32'd4097);
        check("t6_addr", 32'(sif2.chart_addr), 32'd4097);
        check("t6_busy", 32'(sif2.busy), 32'd1);
        check("sb_empty", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
